// File: rtl/handshake_rx.sv
// Slow-domain responder for a four-phase req/ack CDC handshake: synchronises req_async,
// emits one pulse per request and counts deliveries. Define HS_RX_TIMEOUT_EN for the release timeout.
`timescale 1ns/1ps
module handshake_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             clk_slow,
    input  logic             rst_n,
    input  logic             req_async,
    output logic             ack,
    output logic             data_to_slow,
    output logic             busy,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             err_timeout
);

    localparam int unsigned TO_W = 16;

    // Elaboration-time parameter range checks
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("handshake_rx: SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_to
        $error("handshake_rx: TIMEOUT_CYC must be 1..65535");
    end

`ifdef HS_RX_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, ERR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1} state_t;
`endif

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_q, ack_d;
    logic                   pulse_q, pulse_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   req_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
    assign req_s  = sync_q[SYNC_STAGES-1];

`ifdef HS_RX_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        pulse_d = 1'b0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
`ifdef HS_RX_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    pulse_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef HS_RX_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    busy_d  = 1'b0;
                end
`ifdef HS_RX_TIMEOUT_EN
                // Counter value N-1 here means this edge completes N cycles in ACK
                else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                    ack_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ERR: begin
                if (!req_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            ack_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            ack_q   <= ack_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HS_RX_TIMEOUT_EN
    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign ack          = ack_q;
    assign data_to_slow = pulse_q;
    assign busy         = busy_q;
    assign evt_cnt      = cnt_q;

endmodule

// File: tb/tb_handshake_rx.sv
// Scoreboard bench for handshake_rx: an 8-bit-counter instance and a 2-bit-counter
// instance share the request; pulses are matched against queued expected counts.
`timescale 1ns/1ps
module tb_handshake_rx;

    logic       clk_slow  = 1'b0;
    logic       clk_fast  = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_async = 1'b0;

    logic       ack_a, data_a, busy_a, err_a;
    logic [7:0] evt_a;
    logic       ack_b, data_b, busy_b, err_b;
    logic [1:0] evt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q_a[$];
    int exp_q_b[$];
    int model_a  = 0;
    int model_b  = 0;
    logic prev_ack_a  = 1'b0;
    logic prev_data_a = 1'b0;

    always #10 clk_slow = ~clk_slow;
    always #3  clk_fast = ~clk_fast;

    handshake_rx #(.SYNC_STAGES(2), .CNT_W(8), .TIMEOUT_CYC(8)) dut_a (
        .clk_slow(clk_slow), .rst_n(rst_n), .req_async(req_async),
        .ack(ack_a), .data_to_slow(data_a), .busy(busy_a),
        .evt_cnt(evt_a), .err_timeout(err_a)
    );

    handshake_rx #(.SYNC_STAGES(2), .CNT_W(2), .TIMEOUT_CYC(8)) dut_b (
        .clk_slow(clk_slow), .rst_n(rst_n), .req_async(req_async),
        .ack(ack_b), .data_to_slow(data_b), .busy(busy_b),
        .evt_cnt(evt_b), .err_timeout(err_b)
    );

    // Pulse monitor: every pulse must match a queued request, last one cycle, and start a new ack
    always @(negedge clk_slow) begin
        if (rst_n && data_a) begin
            n_checks++;
            if (exp_q_a.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_a_unexpected: evt_cnt=%0d, no request pending", evt_a);
            end else begin
                int e;
                e = exp_q_a.pop_front();
                if (evt_a !== 8'(e)) begin
                    n_fail++;
                    $display("FAIL pulse_a_cnt: got %0d expected %0d", evt_a, e);
                end
            end
            n_checks++;
            if (prev_ack_a !== 1'b0 || prev_data_a !== 1'b0 || ack_a !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse_a_shape: prev_ack=%b prev_pulse=%b ack=%b expected 0 0 1",
                         prev_ack_a, prev_data_a, ack_a);
            end
        end
        if (rst_n && data_b) begin
            n_checks++;
            if (exp_q_b.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_b_unexpected: evt_cnt=%0d, no request pending", evt_b);
            end else begin
                int e;
                e = exp_q_b.pop_front();
                if (evt_b !== 2'(e)) begin
                    n_fail++;
                    $display("FAIL pulse_b_cnt: got %0d expected %0d", evt_b, e);
                end
            end
        end
        prev_ack_a  = ack_a;
        prev_data_a = data_a;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_slow);
    endtask

    task automatic push_req();
        model_a = (model_a + 1) % 256;
        model_b = (model_b + 1) % 4;
        exp_q_a.push_back(model_a);
        exp_q_b.push_back(model_b);
    endtask

    task automatic clear_model();
        model_a = 0;
        model_b = 0;
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_slow);
        req_async = 1'b0;
        rst_n     = 1'b0;
        tick(2);
        clear_model();
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_ack(input logic v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_slow);
            if (ack_a === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++;
        if ({ack_a, data_a, busy_a, evt_a, err_a} !== 12'h000 ||
            {ack_b, data_b, busy_b, evt_b, err_b} !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_values: a=%b%b%b/%0d/%b b=%b%b%b/%0d/%b expected all 0",
                     ack_a, data_a, busy_a, evt_a, err_a, ack_b, data_b, busy_b, evt_b, err_b);
        end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single();
        do_reset();
        req_async = 1'b1;
        push_req();
        tick(2);
        n_checks++;
        if (ack_a !== 1'b0 || data_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: ack=%b pulse=%b expected 0 0", ack_a, data_a);
        end
        tick(1);
        n_checks++;
        if (ack_a !== 1'b1 || data_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rise: ack=%b pulse=%b busy=%b expected 1 1 1", ack_a, data_a, busy_a);
        end
        tick(1);
        n_checks++;
        if (data_a !== 1'b0 || ack_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_width: pulse=%b ack=%b busy=%b expected 0 1 1", data_a, ack_a, busy_a);
        end
        repeat (50) @(posedge clk_fast);
        @(negedge clk_slow);
        req_async = 1'b0;
        tick(2);
        n_checks++;
        if (ack_a !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: ack=%b busy=%b expected 1 1", ack_a, busy_a);
        end
        tick(1);
        n_checks++;
        if (ack_a !== 1'b0 || busy_a !== 1'b0 || evt_a !== 8'd1) begin
            n_fail++;
            $display("FAIL single_release: ack=%b busy=%b evt=%0d expected 0 0 1", ack_a, busy_a, evt_a);
        end
    endtask

    task automatic handshake(output bit ok_rise, output bit ok_fall);
        req_async = 1'b1;
        push_req();
        wait_ack(1'b1, ok_rise);
        req_async = 1'b0;
        wait_ack(1'b0, ok_fall);
    endtask

    task automatic test_back_to_back();
        bit r, f;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            handshake(r, f);
            n_checks++;
            if (!r || !f) begin
                n_fail++;
                $display("FAIL b2b_timeout: hs=%0d rise_ok=%b fall_ok=%b expected 1 1", i, r, f);
            end
        end
        n_checks++;
        if (evt_a !== 8'd4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 4", evt_a);
        end
    endtask

    task automatic test_wrap();
        int seq_b[5] = '{1, 2, 3, 0, 1};
        bit r;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_async = 1'b1;
            push_req();
            wait_ack(1'b1, r);
            n_checks++;
            if (!r || evt_b !== 2'(seq_b[i]) || evt_a !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL wrap_cnt: hs=%0d ok=%b cnt2=%0d cnt8=%0d expected %0d %0d",
                         i, r, evt_b, evt_a, seq_b[i], i + 1);
            end
            req_async = 1'b0;
            wait_ack(1'b0, r);
        end
    endtask

    task automatic test_reset_mid();
        bit r;
        do_reset();
        req_async = 1'b1;
        push_req();
        wait_ack(1'b1, r);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (!r || {ack_a, data_a, busy_a, evt_a, err_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_async: ok=%b ack=%b pulse=%b busy=%b evt=%0d expected all 0",
                     r, ack_a, data_a, busy_a, evt_a);
        end
        @(negedge clk_slow);
        clear_model();
        rst_n = 1'b1;
        push_req();
        tick(2);
        n_checks++;
        if (data_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_early: pulse=%b expected 0", data_a);
        end
        tick(1);
        n_checks++;
        if (data_a !== 1'b1 || evt_a !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_mid_redeliver: pulse=%b evt=%0d expected 1 1", data_a, evt_a);
        end
        tick(6);
        req_async = 1'b0;
        wait_ack(1'b0, r);
    endtask

    task automatic test_timeout();
        logic exp_ack, exp_err;
        do_reset();
        req_async = 1'b1;
        push_req();
        tick(3);
        n_checks++;
        if (ack_a !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_entry: ack=%b expected 1", ack_a);
        end
        for (int j = 1; j <= 27; j++) begin
            tick(1);
`ifdef HS_RX_TIMEOUT_EN
            exp_ack = (j < 8);
            exp_err = (j >= 8);
`else
            exp_ack = 1'b1;
            exp_err = 1'b0;
`endif
            n_checks++;
            if (ack_a !== exp_ack || err_a !== exp_err || busy_a !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_hold: cycle=%0d ack=%b err=%b busy=%b expected %b %b 1",
                         j, ack_a, err_a, busy_a, exp_ack, exp_err);
            end
        end
        req_async = 1'b0;
        tick(8);
`ifdef HS_RX_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        n_checks++;
        if (busy_a !== 1'b0 || ack_a !== 1'b0 || err_a !== exp_err) begin
            n_fail++;
            $display("FAIL timeout_release: busy=%b ack=%b err=%b expected 0 0 %b",
                     busy_a, ack_a, err_a, exp_err);
        end
        do_reset();
        n_checks++;
        if (err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b expected 0", err_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_timeout();
        tick(4);
        n_checks++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: pending a=%0d b=%0d expected 0 0", exp_q_a.size(), exp_q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_rx.md
# handshake_rx

Slow-domain responder for the single-bit request/acknowledge CDC handshake. It takes a level request driven from the fast clock domain and synchronises it into `clk_slow`. For each request it emits exactly one single-cycle pulse and returns a four-phase level acknowledge to the fast-side initiator. It sits at the slow end of the fast-to-slow event crossing and counts delivered events for debug.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in the `req_async` synchroniser. Legal range 2..4.
- `CNT_W`, default 8: width of the delivered-event counter.
- `TIMEOUT_CYC`, default 64: `clk_slow` cycles that ACK may wait for request release. Used only when the timeout feature is compiled in; legal range 1..2^16-1.

Ports:
- `clk_slow`, input, 1: the single clock. All flops are on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_async`, input, 1: level request from the fast domain; asynchronous to `clk_slow`.
- `ack`, output, 1: level acknowledge returned to the fast domain. Registered.
- `data_to_slow`, output, 1: one-cycle event pulse in the `clk_slow` domain. Registered.
- `busy`, output, 1: high while a handshake is in progress (state is not IDLE). Registered.
- `evt_cnt`, output, `CNT_W`: number of delivered pulses, modulo 2^`CNT_W`.
- `err_timeout`, output, 1: sticky timeout flag. Tied 0 when the timeout feature is compiled out.

## Operation
- Synchroniser: shift chain `sync[0..SYNC_STAGES-1]`, reset to 0.
  - `req_s` = last stage.
  - No other logic samples `req_async` directly.
- FSM states: IDLE, ACK, and ERR (ERR exists only when `HS_RX_TIMEOUT_EN` is defined).
- IDLE to ACK when `req_s`=1.
  - On that same edge: `data_to_slow`<=1 for one cycle, `ack`<=1, `busy`<=1, `evt_cnt`<=`evt_cnt`+1.
- ACK to IDLE when `req_s`=0.
  - On that edge: `ack`<=0 and `busy`<=0.
- IDLE with `req_s`=0: hold.
- Exactly one pulse per request rising edge, however long the request stays high.
- A new request is recognised only after IDLE has been re-entered, i.e. after `req_s` has been seen low.
- Counter: `evt_cnt` wraps from 2^`CNT_W`-1 to 0 with no flag.
- Reset values (immediate on `rst_n` falling, asynchronous):
  - `ack`=0, `data_to_slow`=0, `busy`=0, `evt_cnt`=0, `err_timeout`=0.
  - State is IDLE, synchroniser is all zeros, timeout counter is 0.
- Reset mid-handshake: `ack` drops immediately. If `req_async` is still high after reset release, it is treated as a fresh request. It is delivered one more time and counted from 0.

## Timing
- Assume `req_async` changes before rising edge k, with setup met at `sync[0]`.
  - `req_s` is high after edge k+`SYNC_STAGES`-1.
  - `ack` and `data_to_slow` are high after edge k+`SYNC_STAGES` (k+2 at default).
- `data_to_slow` is high for exactly one `clk_slow` cycle.
- `req_async` falling before edge m: `ack` is low after edge m+`SYNC_STAGES`.
- Minimum full handshake on the slow side: 2×`SYNC_STAGES` cycles, plus the fast side's return-synchroniser latency.
- A metastable first sample may add one cycle of latency. The pulse count is never affected.

## Configuration
- `HS_RX_TIMEOUT_EN` defined: request-release timeout is compiled in.
  - A counter clears on entry to ACK and increments each cycle in ACK while `req_s`=1.
  - When the counter reaches `TIMEOUT_CYC`, the FSM goes ACK to ERR. On that edge `ack`<=0, `err_timeout`<=1, and `busy` stays 1.
  - ERR to IDLE when `req_s`=0.
  - `err_timeout` stays set until reset. No pulse is emitted on the ERR to IDLE transition.
- `HS_RX_TIMEOUT_EN` undefined: no counter and no ERR state. ACK waits indefinitely and `err_timeout` is constant 0.

## Test plan
- Reset, then `req_async`=1 held 50 fast cycles (3 ns half-period clock vs 10 ns half-period slow clock), then released. Required response:
  - One `data_to_slow` pulse, 20 ns wide, starting 2 slow edges after the request.
  - `ack` high until 2 edges after the release.
  - `evt_cnt`=1 and `busy` matches `ack`.
- Four back-to-back four-phase handshakes, each new request raised only after `ack` falls. Required: 4 pulses, `evt_cnt`=4, and no pulse while `ack`=1.
- Request held through 2^`CNT_W`+1 handshakes (use `CNT_W`=2, 5 handshakes). Required: `evt_cnt` sequence 1,2,3,0,1.
- `rst_n` asserted low while `ack`=1 with `req_async` held high. Required response:
  - All outputs 0 immediately.
  - After release, exactly one new pulse at edge 2, and `evt_cnt`=1.
- With `HS_RX_TIMEOUT_EN` and `TIMEOUT_CYC`=8, hold `req_async` high for 30 slow cycles. Required response:
  - `ack` falls and `err_timeout` rises 8 cycles after ACK entry, with only one pulse.
  - The FSM returns to IDLE after the release.
  - `err_timeout` stays 1 until reset.
- Without the macro, repeat the previous scenario. Required: `ack` stays high for the full hold and `err_timeout`=0 throughout.
